axis_spi_master: RTL

- AXI-Stream to SPI master. Serializes each s_axis_tx word onto IO0 (MOSI) and captures the word returned on IO1 (MISO) into m_axis_rx. It is the initiating end for axis_spi_slave2 links.
- SPI timing:
  - SCK idles low.
  - Both ends drive data on SCK rising edge and sample on SCK falling edge.
  - MSB first.
  - SS low frames a burst that ends on tlast.
- All logic runs in the aclk domain. SCK is derived from aclk by a divider.

---
 rtl/axis_spi_master.sv | 127 ++++++++++++
 1 files changed

// File: rtl/axis_spi_master.sv
// AXI-Stream to SPI master: shifts tx words out MSB first on IO0 and returns the word captured on IO1.
// SCK idles low; both ends drive on SCK rise and sample on SCK fall; SS frames a burst ending on tlast.
module axis_spi_master #(
   parameter int unsigned C_DATA_WIDTH = 8,
   parameter int unsigned C_CLK_DIV    = 4
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
   input  logic                    s_axis_tx_tlast,
   input  logic                    s_axis_tx_tvalid,
   output logic                    s_axis_tx_tready,
   output logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
   output logic                    m_axis_rx_tvalid,
   input  logic                    m_axis_rx_tready,
   output logic                    SS_O,
   output logic                    SS_T,
   output logic                    SCK_O,
   output logic                    SCK_T,
   output logic                    IO0_O,
   output logic                    IO0_T,
   input  logic                    IO1_I,
   output logic                    busy
);
   localparam int unsigned CW = $clog2(2 * C_CLK_DIV);
   localparam int unsigned BW = $clog2(C_DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_HIGH, S_LOW, S_WAIT, S_HOLD, S_GAP
   } state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           phase_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [C_DATA_WIDTH-1:0] tx_sr, rx_sr, tx_word;
   logic                    last_q, miso_s1, miso_s2;
   logic                    tx_fire, phase_done, gap_done, word_done;

   assign SS_T  = 1'b0;
   assign SCK_T = 1'b0;
   assign IO0_T = 1'b0;
   assign busy  = (state != S_IDLE);

   // No new word may start while an rx beat is still pending.
   assign s_axis_tx_tready = aresetn && (state == S_IDLE || state == S_WAIT) && !m_axis_rx_tvalid;
   assign tx_fire    = s_axis_tx_tvalid && s_axis_tx_tready;
   assign phase_done = (phase_cnt == CW'(C_CLK_DIV - 1));
   assign gap_done   = (phase_cnt == CW'(2 * C_CLK_DIV - 1));
   assign word_done  = (bit_cnt == BW'(C_DATA_WIDTH - 1));
   // A handshake in S_WAIT enters S_HIGH on the same edge, so the MSB must come straight from tdata.
   assign tx_word    = tx_fire ? s_axis_tx_tdata : tx_sr;

   always_ff @(posedge aclk) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (tx_fire)    state_nxt = S_SETUP;
         S_SETUP: if (phase_done) state_nxt = S_HIGH;
         S_HIGH:  if (phase_done) state_nxt = S_LOW;
         S_LOW:   if (phase_done) state_nxt = !word_done ? S_HIGH : (last_q ? S_HOLD : S_WAIT);
         S_WAIT:  if (tx_fire)    state_nxt = S_HIGH;
         S_HOLD:  if (phase_done) state_nxt = S_GAP;
         S_GAP:   if (gap_done)   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      SS_O  = 1'b0;
      SCK_O = 1'b0;
      case (state)
         S_IDLE, S_GAP: SS_O  = 1'b1;
         S_HIGH:        SCK_O = 1'b1;
         default:       ;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         phase_cnt        <= '0;
         bit_cnt          <= '0;
         tx_sr            <= '0;
         rx_sr            <= '0;
         last_q           <= 1'b0;
         miso_s1          <= 1'b0;
         miso_s2          <= 1'b0;
         IO0_O            <= 1'b0;
         m_axis_rx_tdata  <= '0;
         m_axis_rx_tvalid <= 1'b0;
      end else begin
         miso_s1 <= IO1_I;
         miso_s2 <= miso_s1;

         if (state_nxt != state || state == S_IDLE || state == S_WAIT) phase_cnt <= '0;
         else                                                          phase_cnt <= phase_cnt + 1'b1;

         if (tx_fire) begin
            last_q  <= s_axis_tx_tlast;
            bit_cnt <= '0;
         end

         if (state_nxt == S_HIGH && state != S_HIGH) begin
            IO0_O <= tx_word[C_DATA_WIDTH-1];
            tx_sr <= {tx_word[C_DATA_WIDTH-2:0], 1'b0};
         end else if (tx_fire) begin
            tx_sr <= s_axis_tx_tdata;
         end

         if (state_nxt == S_LOW && state != S_LOW)
            rx_sr <= {rx_sr[C_DATA_WIDTH-2:0], miso_s2};

         if (m_axis_rx_tvalid && m_axis_rx_tready) m_axis_rx_tvalid <= 1'b0;

         if (state == S_LOW && phase_done) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (word_done) begin
               m_axis_rx_tdata  <= rx_sr;
               m_axis_rx_tvalid <= 1'b1;
            end
         end
      end
   end
endmodule
